ch_acc_scheduler: RTL and testbench

- Sequences the channel-select datapath across all IN_CH input channels for one input word.
- Accumulates each PE lane's selected partial value over the channels and presents per-PE sums downstream.
- Sits between the per-channel PE result bus and the next accumulation/activation stage.
- Contains the existing channel-slice selector as its datapath and drives its select.

---
 rtl/ch_acc_scheduler_pkg.sv | 20 ++
 rtl/ch_acc_scheduler_sel.sv | 24 ++
 rtl/ch_acc_scheduler.sv | 104 ++++++++++
 tb/tb_ch_acc_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ch_acc_scheduler_pkg.sv
// Shared types and width helpers for the channel-accumulate scheduler.
package ch_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Channel-select width: wide enough to hold IN_CH-1 plus one spare bit.
  function automatic int ch_w_f(input int in_ch);
    return $clog2(in_ch) + 1;
  endfunction

  // Accumulator width: lane width plus headroom for summing in_ch lanes.
  function automatic int acc_w_f(input int width, input int in_ch);
    return width + $clog2(in_ch) + 1;
  endfunction

endpackage

// File: rtl/ch_acc_scheduler_sel.sv
// Channel-slice selector: picks the PE_NUM*WIDTH slice of one input channel.
// A select value outside 0..IN_CH-1 yields all zeros.
module ch_acc_scheduler_sel #(
  parameter int WIDTH  = 30,
  parameter int IN_CH  = 3,
  parameter int PE_NUM = 2,
  parameter int CH_W   = 3
) (
  input  logic [IN_CH*PE_NUM*WIDTH-1:0] i_data,
  input  logic [CH_W-1:0]               i_sel,
  output logic [PE_NUM*WIDTH-1:0]       o_data
);

  // Mux the selected channel's lanes onto the output.
  always_comb begin
    o_data = '0;
    for (int c = 0; c < IN_CH; c++) begin
      if (i_sel == CH_W'(c)) begin
        o_data = i_data[c*PE_NUM*WIDTH +: PE_NUM*WIDTH];
      end
    end
  end

endmodule

// File: rtl/ch_acc_scheduler.sv
// Channel-accumulate scheduler: walks the selector across all IN_CH channels
// of one held input word, sums each PE lane over the channels and presents
// the per-lane sums downstream.
//
// Handshakes: an input word is taken on a rising edge where i_valid && o_ready;
// an output word is taken on a rising edge where o_valid && i_ready. o_valid
// and o_acc hold steady until taken. i_data is not registered, so upstream
// keeps it stable from acceptance until o_ready rises again.
module ch_acc_scheduler
  import ch_acc_pkg::*;
#(
  parameter int WIDTH  = 30,
  parameter int IN_CH  = 3,
  parameter int PE_NUM = 2,
  parameter int CH_W   = ch_w_f(IN_CH),
  parameter int ACC_W  = acc_w_f(WIDTH, IN_CH)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [IN_CH*PE_NUM*WIDTH-1:0] i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [CH_W-1:0]               o_ch_sel,
  output logic                          o_busy,
  output logic [PE_NUM*ACC_W-1:0]       o_acc,
  output logic                          o_valid,
  input  logic                          i_ready
);

  state_e                  state_q;
  logic [CH_W-1:0]         ch_q;
  logic [ACC_W-1:0]        acc_q [PE_NUM];
  logic [ACC_W-1:0]        acc_d [PE_NUM];
  logic [PE_NUM*WIDTH-1:0] sel_data;
  logic                    last_ch;

  assign last_ch = (ch_q == CH_W'(IN_CH - 1));

  ch_acc_scheduler_sel #(
    .WIDTH  (WIDTH),
    .IN_CH  (IN_CH),
    .PE_NUM (PE_NUM),
    .CH_W   (CH_W)
  ) u_sel (
    .i_data (i_data),
    .i_sel  (ch_q),
    .o_data (sel_data)
  );

  // Next lane sums: add the sign-extended lane of the selected channel.
  always_comb begin
    for (int p = 0; p < PE_NUM; p++) begin
      acc_d[p] = acc_q[p] + {{(ACC_W-WIDTH){sel_data[p*WIDTH+WIDTH-1]}},
                             sel_data[p*WIDTH +: WIDTH]};
    end
  end

  // Control FSM with channel counter and lane accumulators.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      for (int p = 0; p < PE_NUM; p++) acc_q[p] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            state_q <= RUN;
            ch_q    <= '0;
            for (int p = 0; p < PE_NUM; p++) acc_q[p] <= '0;
          end
        end
        RUN: begin
          for (int p = 0; p < PE_NUM; p++) acc_q[p] <= acc_d[p];
          if (last_ch) begin
            // Counter parks at 0 so the select reads 0 while results wait.
            ch_q    <= '0;
            state_q <= OUT;
          end else begin
            ch_q <= ch_q + CH_W'(1);
          end
        end
        OUT: begin
          if (i_ready) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ch_q    <= '0;
        end
      endcase
    end
  end

  // Status decodes straight from the state register.
  assign o_ready  = (state_q == IDLE);
  assign o_busy   = (state_q == RUN) || (state_q == OUT);
  assign o_valid  = (state_q == OUT);
  assign o_ch_sel = ch_q;

  for (genvar p = 0; p < PE_NUM; p++) begin : g_acc_out
    assign o_acc[p*ACC_W +: ACC_W] = acc_q[p];
  end

endmodule

// File: tb/tb_ch_acc_scheduler.sv
// Bench for ch_acc_scheduler: table-driven words on an IN_CH=3 build plus
// hand-written backpressure, back-to-back, reset and IN_CH=1 sequences.
module tb_ch_acc_scheduler;

  localparam int WIDTH  = 30;
  localparam int IN_CH  = 3;
  localparam int PE_NUM = 2;
  localparam int CH_W   = $clog2(IN_CH) + 1;
  localparam int ACC_W  = WIDTH + $clog2(IN_CH) + 1;
  localparam int DW     = IN_CH * PE_NUM * WIDTH;
  localparam int ACC1_W = WIDTH + 1;

  // clock / reset
  logic clk;
  logic i_rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (IN_CH=3)
  logic [DW-1:0]         i_data;
  logic                  i_valid;
  logic                  o_ready;
  logic [CH_W-1:0]       o_ch_sel;
  logic                  o_busy;
  logic [2*ACC_W-1:0]    o_acc;
  logic                  o_valid;
  logic                  i_ready;

  ch_acc_scheduler #(.WIDTH(WIDTH), .IN_CH(IN_CH), .PE_NUM(PE_NUM)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_ch_sel(o_ch_sel), .o_busy(o_busy), .o_acc(o_acc),
    .o_valid(o_valid), .i_ready(i_ready)
  );

  // single-channel DUT (IN_CH=1)
  logic [PE_NUM*WIDTH-1:0] d1_data;
  logic                    d1_valid;
  logic                    d1_ready_o;
  logic [0:0]              d1_ch_sel;
  logic                    d1_busy;
  logic [2*ACC1_W-1:0]     d1_acc;
  logic                    d1_valid_o;
  logic                    d1_ready_i;

  ch_acc_scheduler #(.WIDTH(WIDTH), .IN_CH(1), .PE_NUM(PE_NUM)) dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_data(d1_data), .i_valid(d1_valid),
    .o_ready(d1_ready_o), .o_ch_sel(d1_ch_sel), .o_busy(d1_busy), .o_acc(d1_acc),
    .o_valid(d1_valid_o), .i_ready(d1_ready_i)
  );

  // scoreboard
  typedef struct {
    logic [DW-1:0]    data;
    logic [ACC_W-1:0] e0;
    logic [ACC_W-1:0] e1;
  } vec_t;

  vec_t vecs[4];
  logic [2*ACC_W-1:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pack(input int c0p0, input int c0p1,
                                          input int c1p0, input int c1p1,
                                          input int c2p0, input int c2p1);
    logic [DW-1:0] d;
    d = '0;
    d[0*WIDTH +: WIDTH] = WIDTH'(c0p0);
    d[1*WIDTH +: WIDTH] = WIDTH'(c0p1);
    d[2*WIDTH +: WIDTH] = WIDTH'(c1p0);
    d[3*WIDTH +: WIDTH] = WIDTH'(c1p1);
    d[4*WIDTH +: WIDTH] = WIDTH'(c2p0);
    d[5*WIDTH +: WIDTH] = WIDTH'(c2p1);
    return d;
  endfunction

  // driver: one word from IDLE through handshake; hold = cycles of i_ready=0 in OUT
  task automatic run_word(input logic [DW-1:0] d, input logic [ACC_W-1:0] e0,
                          input logic [ACC_W-1:0] e1, input int hold);
    logic [2*ACC_W-1:0] exp;
    chk("ready_before_accept", o_ready, 1);
    i_data  = d;
    i_valid = 1'b1;
    i_ready = (hold == 0);
    exp_q.push_back({e1, e0});
    tick();
    i_valid = 1'b0;
    for (int c = 0; c < IN_CH; c++) begin
      chk("run_ch_sel", o_ch_sel, c);
      chk("run_busy", o_busy, 1);
      chk("run_no_valid", o_valid, 0);
      tick();
    end
    exp = exp_q.pop_front();
    chk("out_valid", o_valid, 1);
    chk("out_acc0", o_acc[0 +: ACC_W], exp[0 +: ACC_W]);
    chk("out_acc1", o_acc[ACC_W +: ACC_W], exp[ACC_W +: ACC_W]);
    chk("out_ch_sel_zero", o_ch_sel, 0);
    chk("out_not_ready", o_ready, 0);
    for (int h = 0; h < hold; h++) begin
      i_valid = h[0];
      tick();
      chk("hold_valid", o_valid, 1);
      chk("hold_acc", o_acc, exp);
      chk("hold_not_ready", o_ready, 0);
      chk("hold_ch_sel", o_ch_sel, 0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    chk("post_hs_valid_low", o_valid, 0);
    chk("post_hs_ready", o_ready, 1);
    chk("post_hs_idle", o_busy, 0);
  endtask

  initial begin : main
    int seen;
    logic [ACC1_W-1:0] e1_0, e1_1;

    i_rst      = 1'b1;
    i_data     = '0;
    i_valid    = 1'b0;
    i_ready    = 1'b1;
    d1_data    = '0;
    d1_valid   = 1'b0;
    d1_ready_i = 1'b1;

    vecs[0] = '{pack(1, 5, 2, 7, 3, 9), ACC_W'(6), ACC_W'(21)};
    vecs[1] = '{pack(-1, 536870911, -1, 536870911, -1, 536870911),
                ACC_W'(-3), ACC_W'(64'd1610612733)};
    vecs[2] = '{pack(-536870912, 100, -536870912, -50, -536870912, 7),
                ACC_W'(-1610612736), ACC_W'(57)};
    vecs[3] = '{pack(10, -7, -20, -8, 30, -9), ACC_W'(20), ACC_W'(-24)};

    // reset state
    tick();
    tick();
    chk("rst_ready", o_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_ch_sel", o_ch_sel, 0);
    chk("rst_acc", o_acc, 0);
    chk("rst1_ready", d1_ready_o, 1);
    chk("rst1_acc", d1_acc, 0);
    i_rst = 1'b0;
    tick();

    // table-driven words
    for (int i = 0; i < 4; i++) run_word(vecs[i].data, vecs[i].e0, vecs[i].e1, 0);

    // backpressure with ignored i_valid pulses
    run_word(vecs[2].data, vecs[2].e0, vecs[2].e1, 10);

    // back-to-back with i_valid held
    i_ready = 1'b1;
    i_data  = vecs[0].data;
    i_valid = 1'b1;
    tick();
    repeat (IN_CH) tick();
    chk("b2b_first_valid", o_valid, 1);
    chk("b2b_first_acc", o_acc, {vecs[0].e1, vecs[0].e0});
    tick();
    chk("b2b_idle_ready", o_ready, 1);
    chk("b2b_idle_busy", o_busy, 0);
    i_data = vecs[3].data;
    tick();
    chk("b2b_second_accepted", o_busy, 1);
    chk("b2b_second_ch0", o_ch_sel, 0);
    i_valid = 1'b0;
    repeat (IN_CH) tick();
    chk("b2b_second_valid", o_valid, 1);
    chk("b2b_second_acc", o_acc, {vecs[3].e1, vecs[3].e0});
    tick();
    chk("b2b_done_ready", o_ready, 1);

    // reset mid-RUN
    i_data  = vecs[1].data;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    chk("mid_run_ch_sel", o_ch_sel, 1);
    #2 i_rst = 1'b1;
    #1;
    chk("async_rst_ready", o_ready, 1);
    chk("async_rst_busy", o_busy, 0);
    chk("async_rst_valid", o_valid, 0);
    chk("async_rst_ch_sel", o_ch_sel, 0);
    chk("async_rst_acc", o_acc, 0);
    @(negedge clk);
    i_rst = 1'b0;
    seen = 0;
    repeat (8) begin
      tick();
      if (o_valid) seen++;
    end
    chk("no_valid_after_reset", seen, 0);
    run_word(vecs[1].data, vecs[1].e0, vecs[1].e1, 0);

    // IN_CH=1 build: {p1:4, p0:-4}
    d1_data[0 +: WIDTH]     = WIDTH'(-4);
    d1_data[WIDTH +: WIDTH] = WIDTH'(4);
    e1_0 = ACC1_W'(-4);
    e1_1 = ACC1_W'(4);
    d1_valid = 1'b1;
    tick();
    d1_valid = 1'b0;
    chk("ch1_run_busy", d1_busy, 1);
    chk("ch1_run_ch_sel", d1_ch_sel, 0);
    chk("ch1_run_no_valid", d1_valid_o, 0);
    tick();
    chk("ch1_valid", d1_valid_o, 1);
    chk("ch1_acc0", d1_acc[0 +: ACC1_W], e1_0);
    chk("ch1_acc1", d1_acc[ACC1_W +: ACC1_W], e1_1);
    tick();
    chk("ch1_post_valid_low", d1_valid_o, 0);
    chk("ch1_post_ready", d1_ready_o, 1);

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
